// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and reset values for the two-requester round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam arb_state_t RST_STATE     = IDLE;
  localparam logic       RST_PRIO      = 1'b0;  // requester 0 preferred after reset
  localparam logic       RST_OUT_VALID = 1'b0;
  localparam logic       RST_OUT_LAST  = 1'b0;
  localparam logic       RST_PKT_OPEN  = 1'b0;

  // Map a requester index to its grant state.
  function automatic arb_state_t grant_of(input logic sel);
    return sel ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle: two valid/ready requesters, one buffered output, status.
interface mux2_rr_arbiter_if #(
  parameter int N = 8
);
  logic         req0_valid;
  logic [N-1:0] req0_data;
  logic         req0_last;
  logic         req0_ready;
  logic         req1_valid;
  logic [N-1:0] req1_data;
  logic         req1_last;
  logic         req1_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         grant_sel;
  logic         busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_last,
    output grant_sel, busy
  );

  // Producer/consumer side
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_last,
    input  grant_sel, busy
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2_n.sv
// Generic N-bit 2:1 multiplexer.
module mux2_n #(
  parameter int N = 8
) (
  input  logic         sel,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  output logic [N-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter_rr_pick_2.sv
// Two-way round-robin pick: prio names the requester that wins a tie.
module rr_pick_2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic any,
  output logic winner
);

  // Winner is the sole valid requester, or prio when both are valid
  always_comb begin
    any    = valid0 | valid1;
    winner = (valid0 && valid1) ? prio : valid1;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one buffered output channel between two
// valid/ready requesters, optionally locking the grant for a whole packet.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOCK_PKT = 1
) (
  input logic              clk,
  input logic              rst,
  mux2_rr_arbiter_if.slave bus
);

  arb_state_t   state_q, state_d;
  logic         prio_q, prio_d;
  logic         pkt_open_q, pkt_open_d;
  logic         grant_sel_q, grant_sel_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         out_last_q, out_last_d;

  logic         can_load;
  logic         ready0, ready1;
  logic         accept;
  logic         granted_valid;
  logic         grant_end;
  logic         pick_prio;
  logic         pick_any;
  logic         pick_winner;
  logic [N:0]   sel_beat;

  // A new beat may enter when the buffer is empty or drains this cycle
  assign can_load      = !out_valid_q || bus.out_ready;
  assign ready0        = (state_q == GRANT0) && can_load;
  assign ready1        = (state_q == GRANT1) && can_load;
  assign accept        = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
  assign granted_valid = grant_sel_q ? bus.req1_valid : bus.req0_valid;

  mux2_n #(.N(N + 1)) u_mux (
    .sel (grant_sel_q),
    .in0 ({bus.req0_last, bus.req0_data}),
    .in1 ({bus.req1_last, bus.req1_data}),
    .out (sel_beat)
  );

  assign grant_end = accept && ((LOCK_PKT == 0) || sel_beat[N]);

  // At grant end the other requester is preferred; otherwise use stored prio
  assign pick_prio = grant_end ? ~grant_sel_q : prio_q;

  rr_pick_2 u_pick (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .prio   (pick_prio),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Next grant: arbitrate from IDLE, hand over at grant end, release a
  // grant that sits between packets with nothing to send
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    pkt_open_d = pkt_open_q;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = grant_of(pick_winner);
      end
      GRANT0, GRANT1: begin
        if (grant_end) begin
          prio_d     = ~grant_sel_q;
          pkt_open_d = 1'b0;
          state_d    = pick_any ? grant_of(pick_winner) : IDLE;
        end else if (accept) begin
          pkt_open_d = 1'b1;
        end else if (!pkt_open_q && !granted_valid) begin
          state_d = pick_any ? grant_of(pick_winner) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_sel_d = (state_d == GRANT1);
  end

  // One-entry output buffer: load on accept, otherwise drain when taken
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_beat[N-1:0];
      out_last_d  = sel_beat[N];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      prio_q      <= RST_PRIO;
      pkt_open_q  <= RST_PKT_OPEN;
      grant_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      pkt_open_q  <= pkt_open_d;
      grant_sel_q <= grant_sel_d;
    end
  end

  // Output buffer registers; reset drops any buffered beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= RST_OUT_VALID;
      out_data_q  <= '0;
      out_last_q  <= RST_OUT_LAST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.grant_sel  = grant_sel_q;
  assign bus.busy       = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: packet-locked instance (a) and
// per-beat arbitration instance (b).
module tb_mux2_rr_arbiter;
  import mux2_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.N(8)) bus_a ();
  mux2_rr_arbiter_if #(.N(8)) bus_b ();

  mux2_rr_arbiter #(.N(8), .LOCK_PKT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mux2_rr_arbiter #(.N(8), .LOCK_PKT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.req0_valid = 1'b0; bus_a.req0_data = 8'h00; bus_a.req0_last = 1'b0;
    bus_a.req1_valid = 1'b0; bus_a.req1_data = 8'h00; bus_a.req1_last = 1'b0;
    bus_a.out_ready  = 1'b0;
    bus_b.req0_valid = 1'b0; bus_b.req0_data = 8'h00; bus_b.req0_last = 1'b0;
    bus_b.req1_valid = 1'b0; bus_b.req1_data = 8'h00; bus_b.req1_last = 1'b0;
    bus_b.out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_b(input int i0, input int i1);
    logic [7:0] d0t [3];
    logic [7:0] d1t [3];
    d0t = '{8'h01, 8'h02, 8'h03};
    d1t = '{8'h11, 8'h12, 8'h13};
    bus_b.req0_valid = 1'b0; bus_b.req0_data = 8'h00; bus_b.req0_last = 1'b0;
    bus_b.req1_valid = 1'b0; bus_b.req1_data = 8'h00; bus_b.req1_last = 1'b0;
    if (i0 < 3) begin
      bus_b.req0_valid = 1'b1;
      bus_b.req0_data  = d0t[i0];
      bus_b.req0_last  = (i0 == 2);
    end
    if (i1 < 3) begin
      bus_b.req1_valid = 1'b1;
      bus_b.req1_data  = d1t[i1];
      bus_b.req1_last  = (i1 == 2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp2 [4];
    logic [8:0] exp5 [6];
    logic [8:0] got5 [6];
    int         i0, i1, nout;
    logic       a0, a1;

    exp2 = '{8'h10, 8'h20, 8'h10, 8'h20};
    exp5 = '{9'h001, 9'h011, 9'h002, 9'h012, 9'h103, 9'h113};
    got5 = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};

    // Reset state, sampled while rst is still high
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_val("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
    check_val("rst_out_data",  32'(bus_a.out_data),  32'h0);
    check_val("rst_out_last",  32'(bus_a.out_last),  32'h0);
    check_val("rst_grant_sel", 32'(bus_a.grant_sel), 32'h0);
    check_val("rst_busy",      32'(bus_a.busy),      32'h0);
    check_val("rst_ready0",    32'(bus_a.req0_ready), 32'h0);
    check_val("rst_ready1",    32'(bus_a.req1_ready), 32'h0);
    check_val("rst_state",     32'(dut_a.state_q),   32'(IDLE));
    check_val("rst_prio",      32'(dut_a.prio_q),    32'h0);
    rst = 1'b0;

    // Single requester, one-beat packet
    bus_a.out_ready = 1'b1;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'hA5; bus_a.req0_last = 1'b1;
    #1;
    check_val("t1_c0_ready0", 32'(bus_a.req0_ready), 32'h0);
    tick();
    check_val("t1_c1_grant_sel", 32'(bus_a.grant_sel), 32'h0);
    check_val("t1_c1_busy",      32'(bus_a.busy),      32'h1);
    check_val("t1_c1_ready0",    32'(bus_a.req0_ready), 32'h1);
    check_val("t1_c1_ready1",    32'(bus_a.req1_ready), 32'h0);
    check_val("t1_c1_out_valid", 32'(bus_a.out_valid), 32'h0);
    tick();
    check_val("t1_c2_out_valid", 32'(bus_a.out_valid), 32'h1);
    check_val("t1_c2_out_data",  32'(bus_a.out_data),  32'hA5);
    check_val("t1_c2_out_last",  32'(bus_a.out_last),  32'h1);
    check_val("t1_c2_prio",      32'(dut_a.prio_q),    32'h1);
    bus_a.req0_valid = 1'b0;
    tick();
    check_val("t1_c3_out_valid", 32'(bus_a.out_valid), 32'h0);
    check_val("t1_c3_busy",      32'(bus_a.busy),      32'h0);
    check_val("t1_c3_state",     32'(dut_a.state_q),   32'(IDLE));

    // Contention with one-beat packets: strict alternation, no gaps
    do_reset();
    bus_a.out_ready = 1'b1;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h10; bus_a.req0_last = 1'b1;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'h20; bus_a.req1_last = 1'b1;
    tick();
    check_val("t2_c1_ready0",    32'(bus_a.req0_ready), 32'h1);
    check_val("t2_c1_ready1",    32'(bus_a.req1_ready), 32'h0);
    check_val("t2_c1_out_valid", 32'(bus_a.out_valid),  32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("t2_beat%0d_valid", k), 32'(bus_a.out_valid), 32'h1);
      check_val($sformatf("t2_beat%0d_data", k),  32'(bus_a.out_data),  32'(exp2[k]));
      check_val($sformatf("t2_beat%0d_sel", k),   32'(bus_a.grant_sel), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    tick();
    check_val("t2_end_busy", 32'(bus_a.busy), 32'h0);

    // Packet lock with a two-cycle valid gap mid-packet
    do_reset();
    bus_a.out_ready = 1'b1;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h01; bus_a.req0_last = 1'b0;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'h77; bus_a.req1_last = 1'b1;
    tick();
    check_val("t3_c1_ready0", 32'(bus_a.req0_ready), 32'h1);
    check_val("t3_c1_ready1", 32'(bus_a.req1_ready), 32'h0);
    tick();
    check_val("t3_c2_out_data", 32'(bus_a.out_data), 32'h01);
    check_val("t3_c2_out_last", 32'(bus_a.out_last), 32'h0);
    bus_a.req0_valid = 1'b0;
    tick();
    check_val("t3_c3_grant_sel", 32'(bus_a.grant_sel), 32'h0);
    check_val("t3_c3_ready1",    32'(bus_a.req1_ready), 32'h0);
    check_val("t3_c3_out_valid", 32'(bus_a.out_valid), 32'h0);
    tick();
    check_val("t3_c4_grant_sel", 32'(bus_a.grant_sel), 32'h0);
    check_val("t3_c4_ready1",    32'(bus_a.req1_ready), 32'h0);
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h02;
    tick();
    check_val("t3_c5_out_data", 32'(bus_a.out_data), 32'h02);
    bus_a.req0_data = 8'h03; bus_a.req0_last = 1'b1;
    tick();
    check_val("t3_c6_out_data",  32'(bus_a.out_data),  32'h03);
    check_val("t3_c6_out_last",  32'(bus_a.out_last),  32'h1);
    check_val("t3_c6_grant_sel", 32'(bus_a.grant_sel), 32'h1);
    check_val("t3_c6_ready1",    32'(bus_a.req1_ready), 32'h1);
    bus_a.req0_valid = 1'b0;
    tick();
    check_val("t3_c7_out_valid", 32'(bus_a.out_valid), 32'h1);
    check_val("t3_c7_out_data",  32'(bus_a.out_data),  32'h77);
    bus_a.req1_valid = 1'b0;
    tick();
    check_val("t3_c8_busy", 32'(bus_a.busy), 32'h0);

    // Backpressure holds the buffered beat and blocks both requesters
    do_reset();
    bus_a.out_ready = 1'b0;
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 8'h3C; bus_a.req0_last = 1'b1;
    tick();
    check_val("t4_c1_ready0", 32'(bus_a.req0_ready), 32'h1);
    tick();
    bus_a.req0_data = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t4_hold%0d_valid", k),  32'(bus_a.out_valid),  32'h1);
      check_val($sformatf("t4_hold%0d_data", k),   32'(bus_a.out_data),   32'h3C);
      check_val($sformatf("t4_hold%0d_ready0", k), 32'(bus_a.req0_ready), 32'h0);
      check_val($sformatf("t4_hold%0d_ready1", k), 32'(bus_a.req1_ready), 32'h0);
      if (k < 3) tick();
    end
    bus_a.out_ready = 1'b1;
    #1;
    check_val("t4_release_ready0", 32'(bus_a.req0_ready), 32'h1);
    tick();
    check_val("t4_next_valid", 32'(bus_a.out_valid), 32'h1);
    check_val("t4_next_data",  32'(bus_a.out_data),  32'h4D);
    bus_a.req0_valid = 1'b0;
    tick();
    check_val("t4_end_busy", 32'(bus_a.busy), 32'h0);
    check_val("t4_end_prio", 32'(dut_a.prio_q), 32'h1);

    // Reset during beat 2 of a requester-1 packet
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 8'hB1; bus_a.req1_last = 1'b0;
    tick();
    check_val("t6_c1_grant_sel", 32'(bus_a.grant_sel), 32'h1);
    check_val("t6_c1_ready1",    32'(bus_a.req1_ready), 32'h1);
    tick();
    check_val("t6_c2_out_data", 32'(bus_a.out_data), 32'hB1);
    bus_a.req1_data = 8'hB2;
    rst = 1'b1;
    tick();
    check_val("t6_rst_out_valid", 32'(bus_a.out_valid),  32'h0);
    check_val("t6_rst_out_data",  32'(bus_a.out_data),   32'h0);
    check_val("t6_rst_grant_sel", 32'(bus_a.grant_sel),  32'h0);
    check_val("t6_rst_busy",      32'(bus_a.busy),       32'h0);
    check_val("t6_rst_ready1",    32'(bus_a.req1_ready), 32'h0);
    check_val("t6_rst_state",     32'(dut_a.state_q),    32'(IDLE));
    check_val("t6_rst_prio",      32'(dut_a.prio_q),     32'h0);
    rst = 1'b0;

    // Per-beat arbitration: two 3-beat packets interleave beat by beat
    do_reset();
    bus_b.out_ready = 1'b1;
    i0 = 0; i1 = 0; nout = 0;
    drive_b(i0, i1);
    for (int c = 0; c < 20; c++) begin
      #1;
      a0 = bus_b.req0_valid && bus_b.req0_ready;
      a1 = bus_b.req1_valid && bus_b.req1_ready;
      tick();
      if (bus_b.out_valid && nout < 6) begin
        got5[nout] = {bus_b.out_last, bus_b.out_data};
        nout++;
      end
      if (a0) i0++;
      if (a1) i1++;
      drive_b(i0, i1);
    end
    check_val("t5_beat_count", 32'(nout), 32'd6);
    for (int k = 0; k < 6; k++)
      check_val($sformatf("t5_beat%0d", k), 32'(got5[k]), 32'(exp5[k]));
    check_val("t5_end_busy", 32'(bus_b.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
